// File: rtl/spi_adc_scanner.sv
// Round-robin SPI ADC scanner: sends the channel address on MOSI, captures a frame,
// averages 2^AVG_LOG2 frames per channel and strobes one word per channel.
//
// state    | meaning
// IDLE     | nCS high, waiting for start_i && enable_i
// CS_SETUP | nCS low, SCLK high, DIV clocks before the first falling edge
// SHIFT    | FRAME_BITS SCLK periods, MOSI on falls, MISO sampled on rises
// CS_HOLD  | SCLK high, nCS low for DIV clocks, sample added to accumulator
// CS_HIGH  | nCS high for NCS_HIGH_CYCLES, then next frame / strobe / idle
module spi_adc_scanner #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int SCLK_FREQ_HZ    = 1_000_000,
    parameter int NUM_CHANNELS    = 4,
    parameter int FRAME_BITS      = 15,
    parameter int DATA_BITS       = 12,
    parameter int AVG_LOG2        = 0,
    parameter int NCS_HIGH_CYCLES = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    input  logic                 MISO_i,
    output logic                 nCS_o,
    output logic                 SCLK_o,
    output logic                 MOSI_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic [2:0]           ch_o,
    output logic                 valid_o,
    output logic                 scan_done_o,
    output logic                 busy_o
);
    localparam int DIV  = CLK_FREQ_HZ / (2 * SCLK_FREQ_HZ);
    localparam int TMAX = (DIV > NCS_HIGH_CYCLES) ? DIV : NCS_HIGH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int BW   = $clog2(FRAME_BITS);
    localparam int AW   = DATA_BITS + AVG_LOG2;
    localparam int FW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [TW-1:0] T_DIV      = TW'(DIV - 1);
    localparam logic [TW-1:0] T_NCS      = TW'(NCS_HIGH_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]    LAST_CH    = 3'(NUM_CHANNELS - 1);

    if (DIV < 1 || NUM_CHANNELS < 1 || NUM_CHANNELS > 8 || DATA_BITS > FRAME_BITS - 3 ||
        AVG_LOG2 < 0 || AVG_LOG2 > 4 || NCS_HIGH_CYCLES < 1) begin : g_bad_params
        $error("spi_adc_scanner: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_HIGH} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic [2:0]            ch_q, ch_d;
    logic                  abort_q, abort_d;
    logic                  ncs_q, ncs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [2:0]            ch_out_q, ch_out_d;
    logic                  valid_q, valid_d, done_q, done_d, busy_q, busy_d;
    logic                  launch, stop;

    // A drop of enable_i at any point in a frame is remembered until the frame ends.
    assign stop = abort_q | ~enable_i;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        frame_d  = frame_q;
        ch_d     = ch_q;
        abort_d  = (state_q == IDLE) ? 1'b0 : stop;
        ncs_d    = ncs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        data_d   = data_q;
        ch_out_d = ch_out_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        launch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && enable_i) begin
                    ch_d    = '0;
                    frame_d = '0;
                    acc_d   = '0;
                    launch  = 1'b1;
                end
            end
            CS_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    mosi_d  = ch_q[2];
                    tmr_d   = T_DIV;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            SHIFT: begin
                if (tmr_q == '0) begin
                    tmr_d = T_DIV;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[FRAME_BITS-2:0], MISO_i};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = CS_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        if (bit_q == BW'(0))      mosi_d = ch_q[1];
                        else if (bit_q == BW'(1)) mosi_d = ch_q[0];
                        else                      mosi_d = 1'b0;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            CS_HOLD: begin
                if (tmr_q == '0) begin
                    acc_d   = acc_q + AW'(sr_q[DATA_BITS-1:0]);
                    state_d = CS_HIGH;
                    ncs_d   = 1'b1;
                    tmr_d   = T_NCS;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            CS_HIGH: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    if (frame_q != LAST_FRAME) begin
                        frame_d = frame_q + 1'b1;
                        launch  = ~stop;
                    end else begin
                        valid_d  = 1'b1;
                        data_d   = acc_q[AW-1:AVG_LOG2];
                        ch_out_d = ch_q;
                        acc_d    = '0;
                        frame_d  = '0;
                        if (ch_q != LAST_CH) begin
                            ch_d   = ch_q + 3'd1;
                            launch = ~stop;
                        end else begin
                            done_d = 1'b1;
                            ch_d   = '0;
                            launch = continuous_i & ~stop;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = CS_SETUP;
            ncs_d   = 1'b0;
            sclk_d  = 1'b1;
            tmr_d   = T_DIV;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            sr_q     <= '0;
            acc_q    <= '0;
            frame_q  <= '0;
            ch_q     <= '0;
            abort_q  <= 1'b0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b1;
            mosi_q   <= 1'b0;
            data_q   <= '0;
            ch_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            acc_q    <= acc_d;
            frame_q  <= frame_d;
            ch_q     <= ch_d;
            abort_q  <= abort_d;
            ncs_q    <= ncs_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            data_q   <= data_d;
            ch_out_q <= ch_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign nCS_o       = ncs_q;
    assign SCLK_o      = sclk_q;
    assign MOSI_o      = mosi_q;
    assign data_o      = data_q;
    assign ch_o        = ch_out_q;
    assign valid_o     = valid_q;
    assign scan_done_o = done_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: four differently parametrised instances, each driven by an
// SPI slave model that answers from a per-channel/per-frame sample table.
module tb_spi_adc_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] rst = 4'hF, en = 4'h0, st = 4'h0, cont = 4'h0;
    wire  [3:0] ncs, sclk, mosi, miso, valid, done, busy;
    wire  [11:0] data [4];
    wire  [2:0]  chn  [4];

    logic [11:0] slv_tab [4][8][4];
    int n_vec = 0;
    int n_bad = 0;

    // u0: defaults, u1: 4x averaging on 2 channels, u2: 2x averaging, u3: DIV=1, 1 channel
    spi_adc_scanner u0 (
        .clk_i(clk), .reset_i(rst[0]), .enable_i(en[0]), .start_i(st[0]),
        .continuous_i(cont[0]), .MISO_i(miso[0]), .nCS_o(ncs[0]), .SCLK_o(sclk[0]),
        .MOSI_o(mosi[0]), .data_o(data[0]), .ch_o(chn[0]), .valid_o(valid[0]),
        .scan_done_o(done[0]), .busy_o(busy[0]));
    spi_adc_scanner #(.NUM_CHANNELS(2), .AVG_LOG2(2)) u1 (
        .clk_i(clk), .reset_i(rst[1]), .enable_i(en[1]), .start_i(st[1]),
        .continuous_i(cont[1]), .MISO_i(miso[1]), .nCS_o(ncs[1]), .SCLK_o(sclk[1]),
        .MOSI_o(mosi[1]), .data_o(data[1]), .ch_o(chn[1]), .valid_o(valid[1]),
        .scan_done_o(done[1]), .busy_o(busy[1]));
    spi_adc_scanner #(.AVG_LOG2(1)) u2 (
        .clk_i(clk), .reset_i(rst[2]), .enable_i(en[2]), .start_i(st[2]),
        .continuous_i(cont[2]), .MISO_i(miso[2]), .nCS_o(ncs[2]), .SCLK_o(sclk[2]),
        .MOSI_o(mosi[2]), .data_o(data[2]), .ch_o(chn[2]), .valid_o(valid[2]),
        .scan_done_o(done[2]), .busy_o(busy[2]));
    spi_adc_scanner #(.NUM_CHANNELS(1), .SCLK_FREQ_HZ(25_000_000), .NCS_HIGH_CYCLES(1)) u3 (
        .clk_i(clk), .reset_i(rst[3]), .enable_i(en[3]), .start_i(st[3]),
        .continuous_i(cont[3]), .MISO_i(miso[3]), .nCS_o(ncs[3]), .SCLK_o(sclk[3]),
        .MOSI_o(mosi[3]), .data_o(data[3]), .ch_o(chn[3]), .valid_o(valid[3]),
        .scan_done_o(done[3]), .busy_o(busy[3]));

    // Slave: drives a 15-bit word {3'b101, sample} MSB first on SCLK falls, shifts the
    // address in on SCLK rises; the sample comes from the address and a per-channel frame count.
    for (genvar g = 0; g < 4; g++) begin : g_slv
        localparam int M = (g == 1) ? 3 : ((g == 2) ? 1 : 0);
        logic        ncs_p = 1'b1, sclk_p = 1'b1, miso_r = 1'b0;
        logic [2:0]  ad = 3'd0;
        logic [11:0] smp = 12'd0;
        logic [14:0] w;
        int          bi = 0;
        int          fc [8];
        logic [2:0]  ad_log [$];
        always @(negedge clk) begin
            if (rst[g]) begin
                for (int k = 0; k < 8; k++) fc[k] = 0;
                bi = 0;
            end else begin
                if (ncs_p && !ncs[g]) begin
                    bi = 0;
                    ad = 3'd0;
                end
                if (!ncs[g] && sclk_p && !sclk[g]) begin
                    if (bi == 3) smp = slv_tab[g][ad][fc[ad] & M];
                    w = {3'b101, smp};
                    if (bi < 15) miso_r = w[14 - bi];
                    bi++;
                end
                if (!ncs[g] && !sclk_p && sclk[g]) begin
                    if (bi <= 3) ad = {ad[1:0], mosi[g]};
                    if (bi == 15) begin
                        fc[ad] = fc[ad] + 1;
                        ad_log.push_back(ad);
                    end
                end
            end
            ncs_p  = ncs[g];
            sclk_p = sclk[g];
        end
        assign miso[g] = miso_r;
    end

    typedef struct {
        int          g;
        bit          start;
        bit          cont;
        int          gap;
        logic [2:0]  ch;
        logic [11:0] data;
        bit          done;
        bit          busy;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(int g, bit s, bit c, int gap, int ch, int d, bit dn, bit b);
        vec_t v;
        v.g = g; v.start = s; v.cont = c; v.gap = gap;
        v.ch = 3'(ch); v.data = 12'(d); v.done = dn; v.busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_valid(input int g, input int bound, output int c, output bit ok);
        ok = 1'b0;
        c  = cyc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (valid[g]) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_start(input int g, output int t);
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    logic [11:0] d0 [4];
    int  tref, tc, c0, c1;
    bit  ok;

    initial begin
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 8; b++)
                for (int f = 0; f < 4; f++) slv_tab[a][b][f] = 12'h000;
        d0[0] = 12'h800; d0[1] = 12'h8AC; d0[2] = 12'h754; d0[3] = 12'hFFF;
        for (int c = 0; c < 4; c++) slv_tab[0][c][0] = d0[c];
        slv_tab[1][0][0] = 12'h800; slv_tab[1][0][1] = 12'h801;
        slv_tab[1][0][2] = 12'h802; slv_tab[1][0][3] = 12'h804;
        for (int f = 0; f < 4; f++) slv_tab[1][1][f] = 12'hFFF;
        slv_tab[2][0][0] = 12'h100; slv_tab[2][0][1] = 12'h102;
        slv_tab[2][1][0] = 12'h3FE; slv_tab[2][1][1] = 12'h401;
        slv_tab[2][2][0] = 12'h555; slv_tab[2][2][1] = 12'h555;
        slv_tab[3][0][0] = 12'hA5C;

        for (int c = 0; c < 4; c++)
            vecs[c] = mk(0, c == 0, 1'b0, 810, c, d0[c], c == 3, c != 3);
        for (int s = 0; s < 3; s++)
            for (int c = 0; c < 4; c++)
                vecs[4 + 4*s + c] = mk(0, s == 0 && c == 0, !(s == 2 && c == 3), 810, c, d0[c],
                                       c == 3, !(s == 2 && c == 3));
        vecs[16] = mk(1, 1'b1, 1'b0, 3240, 0, 12'h801, 1'b0, 1'b1);
        vecs[17] = mk(1, 1'b0, 1'b0, 3240, 1, 12'hFFF, 1'b1, 1'b0);
        vecs[18] = mk(3, 1'b1, 1'b0, 33, 0, 12'hA5C, 1'b1, 1'b0);
        vecs[19] = mk(3, 1'b1, 1'b1, 33, 0, 12'hA5C, 1'b1, 1'b1);
        vecs[20] = mk(3, 1'b0, 1'b1, 33, 0, 12'hA5C, 1'b1, 1'b1);
        vecs[21] = mk(3, 1'b0, 1'b0, 33, 0, 12'hA5C, 1'b1, 1'b0);

        // reset for 3 clocks, then 100 idle clocks
        repeat (3) @(negedge clk);
        rst = 4'h0;
        en  = 4'hF;
        repeat (100) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_ncs", ncs[g], 1);
            chk("rst_sclk", sclk[g], 1);
            chk("rst_valid", valid[g], 0);
            chk("rst_busy", busy[g], 0);
            chk("rst_data", data[g], 0);
        end
        chk("rst_mosi", mosi[0], 0);
        chk("rst_ch", chn[0], 0);
        chk("rst_done", done[0], 0);

        for (int i = 0; i < NV; i++) begin
            cont[vecs[i].g] = vecs[i].cont;
            if (vecs[i].start) pulse_start(vecs[i].g, tref);
            wait_valid(vecs[i].g, vecs[i].gap + 20, tc, ok);
            chk($sformatf("v%0d_strobe", i), ok, 1);
            if (ok) begin
                chk($sformatf("v%0d_gap", i), tc - tref, vecs[i].gap);
                chk($sformatf("v%0d_ch", i), chn[vecs[i].g], vecs[i].ch);
                chk($sformatf("v%0d_data", i), data[vecs[i].g], vecs[i].data);
                chk($sformatf("v%0d_done", i), done[vecs[i].g], vecs[i].done);
                chk($sformatf("v%0d_busy", i), busy[vecs[i].g], vecs[i].busy);
                tref = tc;
            end
        end
        @(negedge clk);
        chk("scan_end_busy", busy[0], 0);
        chk("addr_log_size", g_slv[0].ad_log.size(), 16);
        for (int i = 0; i < 16 && i < g_slv[0].ad_log.size(); i++)
            chk($sformatf("addr_%0d", i), g_slv[0].ad_log[i], i % 4);

        // reset in the middle of SHIFT, then restart at ch0 with an ignored start pulse
        pulse_start(0, tref);
        repeat (200) @(negedge clk);
        chk("mid_busy", busy[0], 1);
        chk("mid_ncs", ncs[0], 0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("mrst_ncs", ncs[0], 1);
        chk("mrst_sclk", sclk[0], 1);
        chk("mrst_mosi", mosi[0], 0);
        chk("mrst_data", data[0], 0);
        chk("mrst_ch", chn[0], 0);
        chk("mrst_valid", valid[0], 0);
        chk("mrst_done", done[0], 0);
        chk("mrst_busy", busy[0], 0);
        repeat (5) @(negedge clk);
        pulse_start(0, tref);
        repeat (100) @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_valid(0, 800, tc, ok);
        chk("restart_strobe", ok, 1);
        chk("restart_gap", tc - tref, 810);
        chk("restart_ch", chn[0], 0);
        chk("restart_data", data[0], 12'h800);
        chk("restart_addr", g_slv[0].ad_log[g_slv[0].ad_log.size() - 1], 0);
        en[0] = 1'b0;

        // enable drop during the second (final) frame of ch1: ch1 still strobes
        pulse_start(2, tref);
        wait_valid(2, 1640, c0, ok);
        chk("drop1_ch0_strobe", ok, 1);
        chk("drop1_ch0_gap", c0 - tref, 1620);
        chk("drop1_ch0_data", data[2], 12'h101);
        wait_until(c0 + 810 + 300);
        en[2] = 1'b0;
        wait_valid(2, 1000, c1, ok);
        chk("drop1_ch1_strobe", ok, 1);
        chk("drop1_ch1_gap", c1 - c0, 1620);
        chk("drop1_ch1_ch", chn[2], 1);
        chk("drop1_ch1_data", data[2], 12'h3FF);
        chk("drop1_done", done[2], 0);
        chk("drop1_busy", busy[2], 0);
        wait_valid(2, 2000, tc, ok);
        chk("drop1_no_more", ok, 0);
        chk("drop1_hold_data", data[2], 12'h3FF);
        chk("drop1_hold_ch", chn[2], 1);

        // enable drop during the first frame of ch2: no ch2 strobe
        en[2] = 1'b1;
        pulse_start(2, tref);
        wait_valid(2, 1640, c0, ok);
        chk("drop2_ch0_strobe", ok, 1);
        wait_valid(2, 1640, c1, ok);
        chk("drop2_ch1_strobe", ok, 1);
        chk("drop2_ch1_busy", busy[2], 1);
        wait_until(c1 + 300);
        en[2] = 1'b0;
        wait_until(c1 + 809);
        chk("drop2_busy_before", busy[2], 1);
        @(negedge clk);
        chk("drop2_busy_after", busy[2], 0);
        chk("drop2_valid_after", valid[2], 0);
        wait_valid(2, 2000, tc, ok);
        chk("drop2_no_ch2", ok, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
